// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory transaction per request on a
// variable-latency bus, with alignment checks, lane steering and timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] load_data,
  output logic [1:0]  fault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_ILL = 2'b10;
  localparam logic [1:0] F_TMO = 2'b11;

  state_e      state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] load_data_q;
  logic [1:0]  fault_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic [31:0] dmem_addr_q;
  logic [3:0]  dmem_be_q;
  logic [31:0] dmem_wdata_q;
  logic [31:0] cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        rd_q;

  logic        accept;
  logic        illegal;
  logic        misal;
  logic        tmo_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] ext_d;

  assign accept = req_valid & (mem_read | mem_write);

  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    unique case (1'b1)
      (mem_read & mem_write):             illegal = 1'b1;
      (func3 == 3'b011):                  illegal = 1'b1;
      (func3 == 3'b110):                  illegal = 1'b1;
      (func3 == 3'b111):                  illegal = 1'b1;
      (mem_write & func3[2]):             illegal = 1'b1;
      default: begin
        misal = (func3[1:0] == 2'b01 & addr[0])
              | (func3 == 3'b010 & addr[1:0] != 2'b00);
      end
    endcase
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    unique case (func3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << addr[1:0];
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
  end

  // Lane select first, then extend from the low byte/half.
  always_comb begin
    shifted = dmem_rdata >> {off_q, 3'b000};
    ext_d   = shifted;
    unique case (f3_q)
      3'b000:  ext_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext_d = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext_d = {24'h0, shifted[7:0]};
      3'b101:  ext_d = {16'h0, shifted[15:0]};
      default: ext_d = shifted;
    endcase
  end

  assign tmo_hit = (TMO != 32'd0) && (cnt_q == TMO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      load_data_q  <= 32'h0;
      fault_q      <= F_OK;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_be_q    <= 4'h0;
      dmem_wdata_q <= 32'h0;
      cnt_q        <= 32'h0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      rd_q         <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            f3_q        <= func3;
            off_q       <= addr[1:0];
            rd_q        <= mem_read;
            req_ready_q <= 1'b0;
            if (illegal || misal) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              fault_q     <= illegal ? F_ILL : F_MIS;
              load_data_q <= 32'h0;
            end else begin
              state_q      <= S_REQ;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= mem_write;
              dmem_addr_q  <= {addr[31:2], 2'b00};
              dmem_be_q    <= be_d;
              dmem_wdata_q <= wdata_d;
              cnt_q        <= 32'h0;
            end
          end
        end
        S_REQ: begin
          if (tmo_hit) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            fault_q     <= F_TMO;
            load_data_q <= 32'h0;
            dmem_req_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (dmem_gnt) begin
              state_q    <= S_WAIT;
              dmem_req_q <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (tmo_hit) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            fault_q     <= F_TMO;
            load_data_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (dmem_rvalid) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              fault_q     <= F_OK;
              load_data_q <= rd_q ? ext_d : 32'h0;
            end
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          load_data_q <= 32'h0;
          fault_q     <= F_OK;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          dmem_req_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign load_data  = load_data_q;
  assign fault      = fault_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign stall      = req_valid & ~rsp_valid_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults,
// timeout with stray response, and asynchronous reset mid-access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] load_data;
  logic [1:0]  fault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .func3(func3), .addr(addr), .store_data(store_data),
    .stall(stall), .rsp_valid(rsp_valid),
    .load_data(load_data), .fault(fault),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  // Drives one request with an immediate grant and a response on the
  // cycle after grant; returns what was observed. Called at a negedge.
  task automatic bus_txn(
    input  logic        rd, wr,
    input  logic [2:0]  f3,
    input  logic [31:0] a, sd, rdat,
    output logic [3:0]  be,
    output logic        we,
    output logic [31:0] da, wd, ld,
    output logic [1:0]  flt,
    output int          lat,
    output logic        sawreq,
    output logic        st_mid
  );
    logic granted;
    granted = 1'b0;
    be = 'x; we = 'x; da = 'x; wd = 'x; ld = 'x; flt = 'x;
    st_mid = 'x;
    lat = 0;
    sawreq = 1'b0;
    req_valid = 1'b1; mem_read = rd; mem_write = wr;
    func3 = f3; addr = a; store_data = sd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (lat == 1) st_mid = stall;
      if (rsp_valid) begin
        ld = load_data;
        flt = fault;
        break;
      end
      if (dmem_req) begin
        if (!sawreq) begin
          be = dmem_be; we = dmem_we;
          da = dmem_addr; wd = dmem_wdata;
        end
        sawreq = 1'b1;
        dmem_gnt = 1'b1;
        granted = 1'b1;
      end else if (granted) begin
        dmem_rvalid = 1'b1;
        dmem_rdata = rdat;
      end
    end
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp got %b exp 0", rsp_valid); end
    n_checks++; if ({dmem_req, dmem_we, dmem_be} !== 6'h0) begin n_fail++; $display("FAIL rst_dmem got %b%b%b exp 0", dmem_req, dmem_we, dmem_be); end
    n_checks++; if ({dmem_addr, dmem_wdata, load_data, fault} !== 98'h0) begin n_fail++; $display("FAIL rst_data got %h %h %h %b exp 0", dmem_addr, dmem_wdata, load_data, fault); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", stall); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw;
    logic [3:0] be; logic we, sr, sm;
    logic [31:0] da, wd, ld; logic [1:0] flt; int lat;
    bus_txn(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (be !== 4'b1111) begin n_fail++; $display("FAIL lw_be got %b exp 1111", be); end
    n_checks++; if (da !== 32'h100 || we !== 1'b0) begin n_fail++; $display("FAIL lw_addr got %h we %b exp 100 we 0", da, we); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d exp 3", lat); end
    n_checks++; if (ld !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got %h exp deadbeef", ld); end
    n_checks++; if (flt !== 2'b00) begin n_fail++; $display("FAIL lw_fault got %b exp 00", flt); end
    n_checks++; if (sm !== 1'b1) begin n_fail++; $display("FAIL lw_stall got %b exp 1", sm); end
    n_checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_no_reaccept got rdy %b rsp %b req %b exp 1 0 0", req_ready, rsp_valid, dmem_req); end
    n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL lw_data_idle got %h exp 0", load_data); end
  endtask

  task automatic test_sub_loads;
    logic [3:0] be; logic we, sr, sm;
    logic [31:0] da, wd, ld; logic [1:0] flt; int lat;
    bus_txn(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (be !== 4'b1000) begin n_fail++; $display("FAIL lb_be got %b exp 1000", be); end
    n_checks++; if (da !== 32'h200) begin n_fail++; $display("FAIL lb_addr got %h exp 200", da); end
    n_checks++; if (ld !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data got %h exp ffffff80", ld); end
    bus_txn(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (ld !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data got %h exp 00000080", ld); end
    bus_txn(1, 0, 3'b001, 32'h202, 32'h0, 32'h80112233,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (be !== 4'b1100) begin n_fail++; $display("FAIL lh_be got %b exp 1100", be); end
    n_checks++; if (ld !== 32'hFFFF8011) begin n_fail++; $display("FAIL lh_data got %h exp ffff8011", ld); end
    bus_txn(1, 0, 3'b101, 32'h202, 32'h0, 32'h80112233,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (ld !== 32'h00008011) begin n_fail++; $display("FAIL lhu_data got %h exp 00008011", ld); end
    bus_txn(1, 0, 3'b000, 32'h201, 32'h0, 32'h80112233,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (be !== 4'b0010 || ld !== 32'h00000022) begin n_fail++; $display("FAIL lb1 got be %b data %h exp 0010 00000022", be, ld); end
  endtask

  task automatic test_stores;
    logic [3:0] be; logic we, sr, sm;
    logic [31:0] da, wd, ld; logic [1:0] flt; int lat;
    bus_txn(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL sh_we got %b exp 1", we); end
    n_checks++; if (be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b exp 1100", be); end
    n_checks++; if (wd !== 32'hABCDABCD) begin n_fail++; $display("FAIL sh_wdata got %h exp abcdabcd", wd); end
    n_checks++; if (da !== 32'h100) begin n_fail++; $display("FAIL sh_addr got %h exp 100", da); end
    n_checks++; if (ld !== 32'h0 || flt !== 2'b00 || lat !== 3) begin n_fail++; $display("FAIL sh_rsp got %h %b lat %0d exp 0 00 3", ld, flt, lat); end
    bus_txn(0, 1, 3'b000, 32'h101, 32'h000000EE, 32'h0,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (be !== 4'b0010 || wd !== 32'hEEEEEEEE) begin n_fail++; $display("FAIL sb got be %b wdata %h exp 0010 eeeeeeee", be, wd); end
    bus_txn(0, 1, 3'b010, 32'h10C, 32'hCAFEF00D, 32'h0,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (be !== 4'b1111 || wd !== 32'hCAFEF00D || da !== 32'h10C) begin n_fail++; $display("FAIL sw got be %b wdata %h addr %h exp 1111 cafef00d 10c", be, wd, da); end
  endtask

  task automatic test_faults;
    logic [3:0] be; logic we, sr, sm;
    logic [31:0] da, wd, ld; logic [1:0] flt; int lat;
    bus_txn(1, 0, 3'b001, 32'h101, 32'h0, 32'h0,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (flt !== 2'b01) begin n_fail++; $display("FAIL lh_mis_fault got %b exp 01", flt); end
    n_checks++; if (sr !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL lh_mis_bus got req %b lat %0d exp 0 1", sr, lat); end
    n_checks++; if (ld !== 32'h0) begin n_fail++; $display("FAIL lh_mis_data got %h exp 0", ld); end
    bus_txn(1, 0, 3'b010, 32'h102, 32'h0, 32'h0,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (flt !== 2'b01 || sr !== 1'b0) begin n_fail++; $display("FAIL lw_mis got %b req %b exp 01 0", flt, sr); end
    bus_txn(0, 1, 3'b100, 32'h100, 32'h0, 32'h0,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (flt !== 2'b10 || sr !== 1'b0 || lat !== 1) begin n_fail++; $display("FAIL sbu_ill got %b req %b lat %0d exp 10 0 1", flt, sr, lat); end
    bus_txn(1, 1, 3'b010, 32'h100, 32'h0, 32'h0,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (flt !== 2'b10 || sr !== 1'b0) begin n_fail++; $display("FAIL rw_ill got %b req %b exp 10 0", flt, sr); end
    bus_txn(1, 0, 3'b011, 32'h101, 32'h0, 32'h0,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (flt !== 2'b10) begin n_fail++; $display("FAIL f3_011_ill got %b exp 10", flt); end
    // No read/write flags: nothing is accepted and the core stays stalled.
    req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (stall !== 1'b1 || req_ready !== 1'b1 || dmem_req !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL noop got stall %b rdy %b req %b rsp %b exp 1 1 0 0", stall, req_ready, dmem_req, rsp_valid); end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    logic [3:0] be; logic we, sr, sm;
    logic [31:0] da, wd, ld; logic [1:0] flt; int lat;
    logic got, r3, r5, rr, stray;
    logic [1:0] f; logic [31:0] d;
    got = 1'b0; r3 = 'x; r5 = 'x; rr = 'x; f = 'x; d = 'x;
    lat = 0;
    req_valid = 1'b1; mem_read = 1'b1; func3 = 3'b010; addr = 32'h300;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      lat++;
      dmem_gnt = (lat == 4);
      if (lat == 3) r3 = dmem_req;
      if (lat == 5) r5 = dmem_req;
      if (rsp_valid) begin
        got = 1'b1; f = fault; d = load_data; rr = dmem_req;
        dmem_gnt = 1'b0;
      end
    end
    n_checks++; if (got !== 1'b1 || lat !== 10) begin n_fail++; $display("FAIL tmo_latency got rsp %b lat %0d exp 1 10", got, lat); end
    n_checks++; if (f !== 2'b11) begin n_fail++; $display("FAIL tmo_fault got %b exp 11", f); end
    n_checks++; if (d !== 32'h0 || rr !== 1'b0) begin n_fail++; $display("FAIL tmo_out got data %h req %b exp 0 0", d, rr); end
    n_checks++; if (r3 !== 1'b1 || r5 !== 1'b0) begin n_fail++; $display("FAIL tmo_req got %b %b exp 1 0", r3, r5); end
    @(negedge clk);
    req_valid = 1'b0; mem_read = 1'b0;
    stray = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h55555555;
    repeat (3) begin
      @(negedge clk);
      stray = stray | rsp_valid;
    end
    dmem_rvalid = 1'b0;
    n_checks++; if (stray !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_stray got rsp %b rdy %b exp 0 1", stray, req_ready); end
    bus_txn(1, 0, 3'b010, 32'h104, 32'h0, 32'h12345678,
            be, we, da, wd, ld, flt, lat, sr, sm);
    n_checks++; if (ld !== 32'h12345678 || flt !== 2'b00 || lat !== 3) begin n_fail++; $display("FAIL tmo_next got %h %b lat %0d exp 12345678 00 3", ld, flt, lat); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    req_valid = 1'b1; mem_read = 1'b1; func3 = 3'b010; addr = 32'h104;
    @(negedge clk);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    n_checks++; if (dmem_addr !== 32'h104 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL mid_wait got addr %h req %b exp 104 0", dmem_addr, dmem_req); end
    #1;
    reset = 1'b0;
    req_valid = 1'b0; mem_read = 1'b0;
    #1;
    n_checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 70'h0) begin n_fail++; $display("FAIL mid_rst_bus got %b %b %b %h %h exp 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata); end
    n_checks++; if ({rsp_valid, load_data, fault} !== 35'h0) begin n_fail++; $display("FAIL mid_rst_rsp got %b %h %b exp 0", rsp_valid, load_data, fault); end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'hA5A5A5A5;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    dmem_rvalid = 1'b0;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_rst_norsp got %b exp 0", seen); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b exp 1", req_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sub_loads();
    test_stores();
    test_faults();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
